sweep_trigger_csr: RTL
======================

# sweep_trigger_csr

Avalon-MM pipelined slave on the master (peripheral-clock) side of the peripheral clock-crossing bridge. It generates the A-line trigger pulse train for the swept-source OCT acquisition and exposes its period, pulse width, lines-per-frame, counters and status as eight 32-bit registers. Reads return through `readdatavalid`, which the bridge forwards upstream. Writes use a one-cycle `waitrequest` handshake that the bridge holds through.

## Interface
Parameters:
- `PERIOD_RESET`, 1000: reset value of PERIOD (trigger period is PERIOD+1 clocks).
- `PULSE_RESET`, 10: reset value of PULSE_WIDTH (high clocks per trigger).
- `LINES_RESET`, 512: reset value of LINES_PER_FRAME.

Ports:
- `clk`  in  1  single clock; every register is on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `address`  in  3  word address (register index 0-7).
- `byteenable`  in  4  write byte lanes.
- `read`  in  1  read request.
- `write`  in  1  write request.
- `writedata`  in  32  write data.
- `readdata`  out  32  read data; valid only while `readdatavalid` is high.
- `readdatavalid`  out  1  read data strobe.
- `waitrequest`  out  1  stall, asserted only for writes.
- `endofpacket`  out  1  STATUS.frame_done, sampled with the read.
- `trigger_out`  out  1  A-line trigger.
- `frame_start`  out  1  one-clock pulse at the start of line 0 of each frame.
- `irq`  out  1  frame_done & irq_en, registered.

## Operation
- Register map (word address):
  - 0 CONTROL, RW: bit0 run, bit1 continuous, bit2 irq_en.
  - 1 PERIOD, RW.
  - 2 PULSE_WIDTH, RW.
  - 3 LINES_PER_FRAME, RW.
  - 4 LINE_COUNT, RO.
  - 5 FRAME_COUNT, RO.
  - 6 STATUS: bit0 busy (RO, equals run); bit1 frame_done (write 1 to clear).
  - 7 SCRATCH, RW.
  - Unused bits read 0. Writes to RO registers are ignored.
- Byte lanes: each RW register updates only the bytes whose `byteenable` bit is set.
- Generator counters: `phase` (32-bit) and `line` (32-bit); both are held at 0 while run=0.
- While run=1:
  - `phase` counts 0..PERIOD_eff and then wraps to 0. PERIOD_eff = max(PERIOD,1).
  - `trigger_out` = (phase < PULSE_WIDTH). If PULSE_WIDTH > PERIOD_eff, the output stays high continuously.
- Line and frame counting:
  - On each `phase` wrap, `line` increments.
  - When `line` reaches LINES_eff-1 and `phase` wraps: `line` goes to 0, FRAME_COUNT increments (wraps modulo 2^32), and frame_done is set. LINES_eff = max(LINES_PER_FRAME,1).
  - If continuous=0, run is also cleared in the same cycle.
- `frame_start` is high in the cycle where run=1, phase=0 and line=0.
- LINE_COUNT reads the live `line` value.
- Writing run=0 mid-frame:
  - `phase` and `line` clear on the next edge and `trigger_out` is low from then on.
  - FRAME_COUNT is held and frame_done is not set.
- Writing run=1 while already running has no effect on the counters.
- Writing any value to FRAME_COUNT is ignored. FRAME_COUNT clears only on reset.
- A frame_done set and a W1C clear in the same cycle: the set wins.
- `read` and `write` asserted together is illegal; the block services the write and ignores the read.
- Reset values:
  - `readdata`=0, `readdatavalid`=0, `waitrequest`=0 (combinational, see Timing).
  - `endofpacket`=0, `trigger_out`=0, `frame_start`=0, `irq`=0.
  - CONTROL=0, PERIOD/PULSE_WIDTH/LINES_PER_FRAME at their parameter values, all counters, STATUS and SCRATCH = 0.
- Reset asserted mid-operation returns everything to reset values immediately. In-flight reads are dropped: no `readdatavalid` follows.

## Timing
- Read accepted in cycle T (`read`=1; never stalled):
  - Stage 1 captures the register mux at the end of T, so the read sees the values present during T.
  - `readdata`, `readdatavalid` and `endofpacket` are registered and high in T+2 only.
  - Fixed latency 2; one read per clock sustained; unlimited outstanding reads.
- Write handshake:
  - `waitrequest` = write & !wr_ack, where wr_ack is a one-bit state set in the cycle after a write is first seen and cleared once the write is accepted.
  - Write in cycle T: `waitrequest`=1 in T. In T+1 `waitrequest`=0, the write is accepted and the register updates at the end of T+1.
  - The new value is visible to a read issued in T+2 and to generator behaviour from T+2.
  - Back-to-back writes take 2 clocks each.
- Generator:
  - `trigger_out`, `frame_start` and `irq` are registered from counter state: one clock after the matching counter value.
  - The first trigger rising edge comes 1 clock after run is written (the clock after it takes effect).
- `irq` follows frame_done & irq_en with 1 clock of delay and drops 1 clock after the W1C clear takes effect.

## Test plan
- Reset check: assert `reset_n`=0 mid-run, then release. All outputs read 0. A read of PERIOD returns 1000 with `readdatavalid` exactly 2 clocks after `read`.
- Single-shot frame: write PERIOD=9, PULSE_WIDTH=3, LINES=4, CONTROL=0x5.
  - Expected: `trigger_out` high 3 of every 10 clocks, exactly 4 pulses, one `frame_start`.
  - After the frame: `irq`=1, STATUS=0x2, FRAME_COUNT=1, CONTROL.run=0.
- Pipelined reads: issue reads to addresses 0..7 on consecutive clocks. Expect 8 consecutive `readdatavalid` cycles in order; `endofpacket` equals frame_done on each.
- Byte lanes: write SCRATCH=0xAABBCCDD with `byteenable`=4'b1111, then write 0x11223344 with 4'b0101. Reading SCRATCH returns 0xAA22CC44. Each write shows exactly 1 `waitrequest` clock.
- Stop mid-frame: in continuous mode with LINES=8, write run=0 at line 3. Expect `trigger_out` low, LINE_COUNT=0, FRAME_COUNT unchanged, frame_done=0.
- W1C race: time the W1C write of STATUS=0x2 to land on the same clock as the second frame's completion. frame_done stays 1 and FRAME_COUNT=2.

Source files
------------

// File: rtl/sweep_trigger_csr.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sweep_trigger_csr: Avalon-MM CSR slave and A-line trigger generator      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module sweep_trigger_csr #(
  parameter logic [31:0] PERIOD_RESET = 32'd1000,
  parameter logic [31:0] PULSE_RESET  = 32'd10,
  parameter logic [31:0] LINES_RESET  = 32'd512
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [2:0]  address,
  input  logic [3:0]  byteenable,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        readdatavalid,
  output logic        waitrequest,
  output logic        endofpacket,
  output logic        trigger_out,
  output logic        frame_start,
  output logic        irq
);

  localparam logic [2:0] C_ADDR_CONTROL = 3'd0;
  localparam logic [2:0] C_ADDR_PERIOD  = 3'd1;
  localparam logic [2:0] C_ADDR_PULSE   = 3'd2;
  localparam logic [2:0] C_ADDR_LINES   = 3'd3;
  localparam logic [2:0] C_ADDR_LINE    = 3'd4;
  localparam logic [2:0] C_ADDR_FRAME   = 3'd5;
  localparam logic [2:0] C_ADDR_STATUS  = 3'd6;
  localparam logic [2:0] C_ADDR_SCRATCH = 3'd7;

  logic        r_wr_ack;
  logic [2:0]  r_control;
  logic [31:0] r_period;
  logic [31:0] r_pulse;
  logic [31:0] r_lines;
  logic [31:0] r_scratch;
  logic [31:0] r_frame_cnt;
  logic        r_frame_done;
  logic [31:0] r_phase;
  logic [31:0] r_line;
  logic        r_rd_valid1;
  logic        r_rd_eop1;
  logic [31:0] r_rd_data1;

  logic        w_wr_accept;
  logic        w_rd;
  logic        w_run;
  logic        w_cont;
  logic        w_irq_en;
  logic        w_ctrl_wr;
  logic        w_status_clr;
  logic [31:0] w_period_eff;
  logic [31:0] w_lines_last;
  logic        w_phase_wrap;
  logic        w_frame_end;
  logic [31:0] w_rdmux;

  function automatic logic [31:0] f_merge(input logic [31:0] old_val,
                                          input logic [31:0] new_val,
                                          input logic [3:0]  be);
    f_merge = old_val;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) f_merge[8*i +: 8] = new_val[8*i +: 8];
    end
  endfunction

  // The write is held by the master; the second cycle of it is the accept cycle.
  assign waitrequest  = write & ~r_wr_ack;
  assign w_wr_accept  = write & r_wr_ack;
  assign w_rd         = read & ~write;

  assign w_run        = r_control[0];
  assign w_cont       = r_control[1];
  assign w_irq_en     = r_control[2];
  assign w_ctrl_wr    = w_wr_accept & (address == C_ADDR_CONTROL) & byteenable[0];
  assign w_status_clr = w_wr_accept & (address == C_ADDR_STATUS) & byteenable[0] & writedata[1];

  assign w_period_eff = (r_period == 32'd0) ? 32'd1 : r_period;
  assign w_lines_last = (r_lines == 32'd0) ? 32'd0 : r_lines - 32'd1;
  // >= keeps the counters bounded if PERIOD/LINES are lowered mid-line.
  assign w_phase_wrap = w_run & (r_phase >= w_period_eff);
  assign w_frame_end  = w_phase_wrap & (r_line >= w_lines_last);

  always_comb begin
    w_rdmux = 32'd0;
    case (address)
      C_ADDR_CONTROL: w_rdmux = {29'd0, r_control};
      C_ADDR_PERIOD:  w_rdmux = r_period;
      C_ADDR_PULSE:   w_rdmux = r_pulse;
      C_ADDR_LINES:   w_rdmux = r_lines;
      C_ADDR_LINE:    w_rdmux = r_line;
      C_ADDR_FRAME:   w_rdmux = r_frame_cnt;
      C_ADDR_STATUS:  w_rdmux = {30'd0, r_frame_done, w_run};
      C_ADDR_SCRATCH: w_rdmux = r_scratch;
      default:        w_rdmux = 32'd0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ack  <= 1'b0;
      r_control <= 3'd0;
      r_period  <= PERIOD_RESET;
      r_pulse   <= PULSE_RESET;
      r_lines   <= LINES_RESET;
      r_scratch <= 32'd0;
    end else begin
      r_wr_ack <= write & ~r_wr_ack;
      if (w_wr_accept) begin
        case (address)
          C_ADDR_CONTROL: if (byteenable[0]) r_control <= writedata[2:0];
          C_ADDR_PERIOD:  r_period  <= f_merge(r_period, writedata, byteenable);
          C_ADDR_PULSE:   r_pulse   <= f_merge(r_pulse, writedata, byteenable);
          C_ADDR_LINES:   r_lines   <= f_merge(r_lines, writedata, byteenable);
          C_ADDR_SCRATCH: r_scratch <= f_merge(r_scratch, writedata, byteenable);
          default: ;
        endcase
      end
      // Single-shot stop, unless software rewrites CONTROL on that same clock.
      if (w_frame_end && !w_cont && !w_ctrl_wr) r_control[0] <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_phase      <= 32'd0;
      r_line       <= 32'd0;
      r_frame_cnt  <= 32'd0;
      r_frame_done <= 1'b0;
      trigger_out  <= 1'b0;
      frame_start  <= 1'b0;
      irq          <= 1'b0;
    end else begin
      if (!w_run) begin
        r_phase <= 32'd0;
        r_line  <= 32'd0;
      end else if (w_phase_wrap) begin
        r_phase <= 32'd0;
        r_line  <= w_frame_end ? 32'd0 : r_line + 32'd1;
      end else begin
        r_phase <= r_phase + 32'd1;
      end
      if (w_frame_end) r_frame_cnt <= r_frame_cnt + 32'd1;
      if (w_frame_end)       r_frame_done <= 1'b1;
      else if (w_status_clr) r_frame_done <= 1'b0;
      trigger_out <= w_run & (r_phase < r_pulse);
      frame_start <= w_run & (r_phase == 32'd0) & (r_line == 32'd0);
      irq         <= r_frame_done & w_irq_en;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_valid1   <= 1'b0;
      r_rd_eop1     <= 1'b0;
      r_rd_data1    <= 32'd0;
      readdatavalid <= 1'b0;
      endofpacket   <= 1'b0;
      readdata      <= 32'd0;
    end else begin
      r_rd_valid1   <= w_rd;
      r_rd_eop1     <= w_rd & r_frame_done;
      r_rd_data1    <= w_rd ? w_rdmux : 32'd0;
      readdatavalid <= r_rd_valid1;
      endofpacket   <= r_rd_eop1;
      readdata      <= r_rd_data1;
    end
  end

endmodule
`default_nettype wire
